// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver for the MIDI input path.
// Samples the rx line with a tick OVERSAMPLE times per bit, deframes
// start/8 data/stop, and strobes dataReady (or frameError) for one clk.
// Optional macro UART_RX_MAJORITY_EN: each bit value becomes the 2-of-3
// majority of the samples at mid-1, mid and mid+1, decided at mid+1.
module uart_rx #(
  parameter int unsigned CLK_FREQ   = 150_000_000,
  parameter int unsigned BAUD_RATE  = 38400,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       dataReady,
  output logic [7:0] dataOut,
  output logic       frameError
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TW  = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] BIT_DEC  = TW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
  // Decision is taken one tick after the nominal mid point so that the
  // three samples mid-1/mid/mid+1 are all available.
  localparam logic [TW-1:0] START_DEC = TW'(OVERSAMPLE / 2);
`else
  localparam logic [TW-1:0] START_DEC = TW'(OVERSAMPLE / 2 - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state, state_nx;
  logic          rx_m, rx_s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          bit_val;

  logic          div_clr;
  logic          tick_clr;
  logic          bit_clr;
  logic          shift_en;
  logic          load_out;
  logic          ferr;

  assign tick = (div_cnt == DIV_LAST);

`ifdef UART_RX_MAJORITY_EN
  logic s_a, s_b;

  // Keep the line values seen at the previous two ticks for the vote.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_a <= 1'b1;
      s_b <= 1'b1;
    end else if (tick) begin
      s_a <= s_b;
      s_b <= rx_s;
    end
  end

  assign bit_val = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // Two-flop synchronizer for the asynchronous rx pin; idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Free-running tick divider, re-phased to the start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (div_clr || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Tick position within the current bit and data bit index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (tick_clr) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= (tick_cnt == BIT_DEC) ? '0 : tick_cnt + TW'(1);
      end
      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Data shift register (LSB first) and registered output strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg      <= '0;
      dataOut    <= '0;
      dataReady  <= 1'b0;
      frameError <= 1'b0;
    end else begin
      if (shift_en) begin
        shreg <= {bit_val, shreg[7:1]};
      end
      if (load_out) begin
        dataOut <= shreg;
      end
      dataReady  <= load_out;
      frameError <= ferr;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next-state and control decode.
  always_comb begin
    state_nx = state;
    div_clr  = 1'b0;
    tick_clr = 1'b0;
    bit_clr  = 1'b0;
    shift_en = 1'b0;
    load_out = 1'b0;
    ferr     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_nx = S_START;
          div_clr  = 1'b1;
          tick_clr = 1'b1;
        end
      end
      S_START: begin
        if (tick && tick_cnt == START_DEC) begin
          if (!bit_val) begin
            state_nx = S_DATA;
            tick_clr = 1'b1;
            bit_clr  = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick && tick_cnt == BIT_DEC) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
            state_nx = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick && tick_cnt == BIT_DEC) begin
          if (bit_val) begin
            load_out = 1'b1;
            state_nx = S_IDLE;
          end else begin
            ferr     = 1'b1;
            state_nx = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed tests for uart_rx, run with a reduced clock so the
// divider is 8 (128 clk per bit) and the run stays short.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 4_915_200;
  localparam int unsigned BAUD     = 38400;
  localparam int unsigned OS       = 16;
  localparam int unsigned DIV      = CLK_FREQ / (BAUD * OS);

  localparam real CLK_NS  = 1.0e9 / CLK_FREQ;
  localparam real BIT_NS  = 1.0e9 / BAUD;
  localparam real SLOW_NS = 1.0e9 / 37260;
  localparam real FAST_NS = 1.0e9 / 39550;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       dataReady;
  logic [7:0] dataOut;
  logic       frameError;

  int n_cmp;
  int n_bad;

  // Event monitor state, cleared by clear_mon.
  int         rdy_cnt;
  int         ferr_cnt;
  int         width_err;
  int         both_err;
  real        rdy_time;
  real        t_start;
  logic [7:0] q[$];
  logic       prev_rdy;
  logic       prev_ferr;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD),
    .OVERSAMPLE(OS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .dataReady (dataReady),
    .dataOut   (dataOut),
    .frameError(frameError)
  );

  initial clk = 1'b0;
  always #(CLK_NS / 2.0) clk = ~clk;

  always @(negedge clk) begin
    if (dataReady === 1'b1) begin
      rdy_cnt++;
      q.push_back(dataOut);
      if (rdy_cnt == 1) rdy_time = $realtime;
      if (prev_rdy === 1'b1) width_err++;
    end
    if (frameError === 1'b1) begin
      ferr_cnt++;
      if (prev_ferr === 1'b1) width_err++;
    end
    if (dataReady === 1'b1 && frameError === 1'b1) both_err++;
    prev_rdy  = dataReady;
    prev_ferr = frameError;
  end

  task automatic clear_mon();
    rdy_cnt   = 0;
    ferr_cnt  = 0;
    width_err = 0;
    both_err  = 0;
    rdy_time  = 0.0;
    q.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input real bit_ns);
    rx      = 1'b0;
    t_start = $realtime;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bit_ns);
    end
    rx = stop;
    #(bit_ns);
  endtask

  function automatic logic [7:0] q_at(input int idx);
    if (idx < q.size()) return q[idx];
    return 8'hxx;
  endfunction

  task automatic test_reset();
    int bad_cycles;
    reset = 1'b0;
    rx    = 1'b1;
    #100;
    n_cmp++;
    if (dataReady !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", dataReady); end
    n_cmp++;
    if (frameError !== 1'b0) begin n_bad++; $display("FAIL rst_ferr: got %b want 0", frameError); end
    n_cmp++;
    if (dataOut !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", dataOut); end
    @(negedge clk);
    reset = 1'b1;
    clear_mon();
    bad_cycles = 0;
    for (int i = 0; i < 10 * OS * DIV; i++) begin
      @(negedge clk);
      if (dataOut !== 8'h00 || dataReady !== 1'b0 || frameError !== 1'b0) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles != 0) begin n_bad++; $display("FAIL idle_quiet: got %0d bad cycles want 0", bad_cycles); end
  endtask

  task automatic test_single();
    real lat, lo, hi;
    clear_mon();
    send_byte(8'h90, 1'b1, BIT_NS);
    #(BIT_NS);
    lat = rdy_time - t_start;
    lo  = 9.5 * BIT_NS - 2.0 * CLK_NS;
`ifdef UART_RX_MAJORITY_EN
    hi  = 9.5 * BIT_NS + 5.0 * CLK_NS + DIV * CLK_NS;
`else
    hi  = 9.5 * BIT_NS + 5.0 * CLK_NS;
`endif
    n_cmp++;
    if (rdy_cnt != 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", rdy_cnt); end
    n_cmp++;
    if (q_at(0) !== 8'h90) begin n_bad++; $display("FAIL single_data: got %h want 90", q_at(0)); end
    n_cmp++;
    if (lat < lo || lat > hi) begin n_bad++; $display("FAIL single_latency: got %0.1f ns want %0.1f..%0.1f", lat, lo, hi); end
    n_cmp++;
    if (width_err != 0) begin n_bad++; $display("FAIL single_width: got %0d wide pulses want 0", width_err); end
    n_cmp++;
    if (ferr_cnt != 0) begin n_bad++; $display("FAIL single_ferr: got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[3];
    exp_b[0] = 8'h90;
    exp_b[1] = 8'h3C;
    exp_b[2] = 8'h7F;
    clear_mon();
    for (int i = 0; i < 3; i++) send_byte(exp_b[i], 1'b1, BIT_NS);
    #(BIT_NS);
    n_cmp++;
    if (rdy_cnt != 3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", rdy_cnt); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (q_at(i) !== exp_b[i]) begin n_bad++; $display("FAIL b2b_data%0d: got %h want %h", i, q_at(i), exp_b[i]); end
    end
    n_cmp++;
    if (ferr_cnt != 0) begin n_bad++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt); end
    n_cmp++;
    if (width_err != 0) begin n_bad++; $display("FAIL b2b_width: got %0d wide pulses want 0", width_err); end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0;
    #1000;
    rx = 1'b1;
    #(2.0 * BIT_NS);
    n_cmp++;
    if (rdy_cnt != 0) begin n_bad++; $display("FAIL glitch_ready: got %0d want 0", rdy_cnt); end
    n_cmp++;
    if (ferr_cnt != 0) begin n_bad++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt); end
    clear_mon();
    send_byte(8'h55, 1'b1, BIT_NS);
    #(BIT_NS);
    n_cmp++;
    if (rdy_cnt != 1) begin n_bad++; $display("FAIL glitch_next_count: got %0d want 1", rdy_cnt); end
    n_cmp++;
    if (dataOut !== 8'h55) begin n_bad++; $display("FAIL glitch_next_data: got %h want 55", dataOut); end
  endtask

  task automatic test_frame_error();
    clear_mon();
    send_byte(8'hA5, 1'b0, BIT_NS);
    #(2.0 * BIT_NS);
    rx = 1'b1;
    #(BIT_NS);
    n_cmp++;
    if (ferr_cnt != 1) begin n_bad++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt); end
    n_cmp++;
    if (rdy_cnt != 0) begin n_bad++; $display("FAIL ferr_ready: got %0d want 0", rdy_cnt); end
    n_cmp++;
    if (dataOut !== 8'h55) begin n_bad++; $display("FAIL ferr_hold: got %h want 55", dataOut); end
    n_cmp++;
    if (both_err != 0 || width_err != 0) begin n_bad++; $display("FAIL ferr_strobes: got both=%0d wide=%0d want 0/0", both_err, width_err); end
    clear_mon();
    send_byte(8'h42, 1'b1, BIT_NS);
    #(BIT_NS);
    n_cmp++;
    if (rdy_cnt != 1 || q_at(0) !== 8'h42) begin n_bad++; $display("FAIL ferr_next: got count=%0d data=%h want 1/42", rdy_cnt, q_at(0)); end
  endtask

  task automatic test_reset_abort();
    clear_mon();
    rx = 1'b0;
    #(BIT_NS);
    rx = 1'b1;
    #(4.5 * BIT_NS);
    reset = 1'b0;
    #100;
    reset = 1'b1;
    #(4.5 * BIT_NS);
    #(BIT_NS);
    n_cmp++;
    if (rdy_cnt != 0 || ferr_cnt != 0) begin n_bad++; $display("FAIL abort_strobe: got rdy=%0d ferr=%0d want 0/0", rdy_cnt, ferr_cnt); end
    n_cmp++;
    if (dataOut !== 8'h00) begin n_bad++; $display("FAIL abort_data: got %h want 00", dataOut); end
    clear_mon();
    send_byte(8'h01, 1'b1, BIT_NS);
    #(BIT_NS);
    n_cmp++;
    if (rdy_cnt != 1 || q_at(0) !== 8'h01) begin n_bad++; $display("FAIL abort_next: got count=%0d data=%h want 1/01", rdy_cnt, q_at(0)); end
  endtask

  task automatic test_baud_tolerance();
    clear_mon();
    send_byte(8'hC3, 1'b1, SLOW_NS);
    #(SLOW_NS);
    n_cmp++;
    if (rdy_cnt != 1 || q_at(0) !== 8'hC3) begin n_bad++; $display("FAIL slow_baud: got count=%0d data=%h want 1/c3", rdy_cnt, q_at(0)); end
    clear_mon();
    send_byte(8'h3A, 1'b1, FAST_NS);
    #(FAST_NS);
    n_cmp++;
    if (rdy_cnt != 1 || q_at(0) !== 8'h3A) begin n_bad++; $display("FAIL fast_baud: got count=%0d data=%h want 1/3a", rdy_cnt, q_at(0)); end
    n_cmp++;
    if (ferr_cnt != 0) begin n_bad++; $display("FAIL baud_ferr: got %0d want 0", ferr_cnt); end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    prev_rdy  = 1'b0;
    prev_ferr = 1'b0;
    t_start   = 0.0;
    reset     = 1'b0;
    rx        = 1'b1;
    clear_mon();
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_abort();
    test_baud_tolerance();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver for the MIDI input path. It samples the asynchronous rx line with a 16x oversampled bit clock derived from clk, and deframes 8N1 characters. Each received byte is presented to midi_decoder as a one-cycle dataReady strobe with dataOut valid in the same cycle. It sits between the board MIDI/UART input pin and midi_decoder.

Parameters:
CLK_FREQ, 150_000_000, system clock frequency in Hz
BAUD_RATE, 38400, serial bit rate in bit/s
OVERSAMPLE, 16, sample ticks per bit; must be even and >= 8

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
rx  input  1  asynchronous serial line; idle high
dataReady  output  1  one-cycle strobe: dataOut holds a valid received byte
dataOut  output  8  received byte, LSB received first; holds until next good byte
frameError  output  1  one-cycle strobe: stop bit sampled low

Behaviour:
- Reset values: dataReady=0, dataOut=8'h00, frameError=0, state=IDLE, synchronizer flops=1, counters=0.
- Synchronizer: rx passes through a 2-FF synchronizer (reset value 1). All decisions use the synchronized value rx_s.
- Tick generator: free-running divider DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), using integer truncation (default 244, giving a bit period of 3904 clk, 0.06% error).
  - Emits a one-clk tick when the count wraps DIV-1 -> 0.
  - The counter is cleared on entry to START so the first tick is phase-aligned to the start edge.
- tick_cnt counts ticks within a bit (0..OVERSAMPLE-1). bit_cnt counts 0..7.
- FSM:
  - IDLE: on rx_s==0, go to START and clear tick_cnt and the divider.
  - START: at tick_cnt==OVERSAMPLE/2-1 (mid start bit), sample the line.
    - Sample 0 -> go to DATA and clear tick_cnt and bit_cnt.
    - Sample 1 -> false start (glitch); return to IDLE with no output.
  - DATA: every OVERSAMPLE ticks (mid-bit), shift the sample into shreg[7] and shift right.
    - After bit_cnt==7 is sampled, go to STOP.
  - STOP: at the mid-bit sample point:
    - Sample 1 -> dataOut<=shreg and dataReady=1 for exactly one clk; go to IDLE.
    - Sample 0 -> frameError=1 for one clk; dataOut is unchanged; go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. No new frame starts while the line is held low.
- Latency: dataReady rises 1 clk after the mid-stop-bit tick, which is about 9.5 bit periods plus 3 clk after the start falling edge at the pin.
- Back-to-back frames: IDLE is reached at mid-stop, so a start edge arriving right at the end of the stop bit is caught. No gap is required.
- There is no flow control. The consumer must take the byte in the dataReady cycle. A new byte overwrites dataOut.
- dataReady and frameError are never asserted in the same cycle.
- Reset assertion mid-frame aborts the frame immediately with no strobe. After release the block waits in IDLE for the next falling edge.
  - If rx is low at release, it is treated as a start; a false start is rejected by the mid-bit check.
- Tolerance: a frame must decode correctly with the sender's baud rate within ±3% of BAUD_RATE.

Optional Feature:
UART_RX_MAJORITY_EN:
- Defined: each bit value (start, data, stop) is the 2-of-3 majority of samples at tick_cnt = mid-1, mid, mid+1, where mid = OVERSAMPLE/2-1 for the start bit and OVERSAMPLE-1 relative to the bit start for the others.
  - The decision is registered at mid+1, adding 1 tick of latency to the dataReady timing.
- Not defined: a single sample is taken at mid, as described above.

Test Plan:
- Reset low 100 ns with rx=1, then release and idle 10 bit periods -> dataReady=0, frameError=0, dataOut=8'h00 throughout.
- Send 8'h90 at 38400 baud with a valid stop bit -> exactly one dataReady pulse 1 clk wide with dataOut=8'h90, within 9.5 bit periods + 5 clk of the start edge.
- Send 8'h90, 8'h3C, 8'h7F back-to-back with no idle gap -> three dataReady pulses with dataOut 8'h90, 8'h3C, 8'h7F in order, and no frameError.
- Drive a 1 µs low glitch on idle rx -> no dataReady or frameError. Then send 8'h55 -> dataOut=8'h55.
- Send 8'hA5 with the stop bit forced 0 and the line held low for 2 bit periods, then high, then send 8'h42:
  - frameError pulses once; no dataReady for 8'hA5; dataOut stays at its prior value.
  - Next, dataReady pulses with dataOut=8'h42.
- Assert reset mid-data-bit 4 of 8'hFF, release, then send 8'h01 -> no output for the aborted frame, then dataReady with dataOut=8'h01. Repeat with the sender at 37260 and 39550 baud (±3%) -> correct bytes.
